// File: rtl/misr_pkg.sv
// misr_pkg: shared FSM state type, default polynomial/seed and sample-counter width.
package misr_pkg;
  typedef enum logic [1:0] {IDLE, CAPTURE, COMPARE, DONE} state_e;
  localparam logic [7:0] DEF_POLY = 8'h1D;
  localparam logic [7:0] DEF_SEED = 8'h00;
  localparam int CNT_W = 8;
endpackage

// File: rtl/misr_core.sv
// misr_core: signature register with polynomial feedback, seed load and zero-fill shift.
module misr_core
  import misr_pkg::*;
#(
  parameter int SIG_W = 8,
  parameter logic [SIG_W-1:0] POLY = SIG_W'(DEF_POLY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic             shift,
  input  logic [2:0]       smp,
  input  logic [SIG_W-1:0] seed,
  output logic [SIG_W-1:0] sig
);
  logic [SIG_W-1:0] sig_q, sig_d, shl;
  always_comb begin
    shl = {sig_q[SIG_W-2:0], 1'b0};
    sig_d = load ? seed : en ? (shl ^ (sig_q[SIG_W-1] ? POLY : '0) ^ SIG_W'(smp)) : shift ? shl : sig_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sig_q <= '0;
    else sig_q <= sig_d;
  assign sig = sig_q;
endmodule

// File: rtl/misr_signature_checker.sv
// misr_signature_checker: captures WINDOW 3-bit samples into a MISR and compares against gold_sig.
// Defining MISR_SCAN_OUT_EN adds scan_en/scan_out to shift the signature out while in DONE.
module misr_signature_checker
  import misr_pkg::*;
#(
  parameter int SIG_W = 8,
  parameter int WINDOW = 16,
  parameter logic [SIG_W-1:0] POLY = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED = SIG_W'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             p1,
  input  logic             p2,
  input  logic             p3,
  input  logic [SIG_W-1:0] gold_sig,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
`ifdef MISR_SCAN_OUT_EN
  ,
  input  logic             scan_en,
  output logic             scan_out
`endif
);
  localparam logic [CNT_W-1:0] WIN = CNT_W'(WINDOW);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic go, shift;
  assign go = start && (state_q == IDLE || state_q == DONE);
`ifdef MISR_SCAN_OUT_EN
  assign shift = (state_q == DONE) && scan_en;
  assign scan_out = signature[SIG_W-1];
`else
  assign shift = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pass_d = pass_q;
    if (go) begin
      state_d = CAPTURE;
      cnt_d = '0;
      pass_d = 1'b0;
    end else if (state_q == CAPTURE) begin
      cnt_d = (cnt_q < WIN) ? cnt_q + 1'b1 : cnt_q;
      state_d = (cnt_q == WIN - 1'b1) ? COMPARE : CAPTURE;
    end else if (state_q == COMPARE) begin
      pass_d = (signature == gold_sig);
      state_d = DONE;
    end
    busy_d = (state_d == CAPTURE) || (state_d == COMPARE);
    done_d = (state_d == DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  misr_core #(.SIG_W(SIG_W), .POLY(POLY)) u_core (
    .clk(clk),
    .rst_n(rst_n),
    .load(go),
    .en(state_q == CAPTURE),
    .shift(shift),
    .smp({p3, p2, p1}),
    .seed(SEED),
    .sig(signature)
  );
  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;
endmodule

// File: tb/tb_misr_signature_checker.sv
// tb_misr_signature_checker: randomized self-checking bench against a GF(2) polynomial reference model.
module tb_misr_signature_checker;
  typedef logic [2:0] q3_t[$];
  logic clk = 0, rst_n = 0;
  logic [3:0] st = '0, bz, dn, ps;
  logic p1 = 0, p2 = 0, p3 = 0;
  logic [7:0] gold = '0;
  logic [7:0] sg[4];
  int passed = 0, total = 0;
`ifdef MISR_SCAN_OUT_EN
  logic scan_en = 0;
  logic [3:0] so;
`endif
  always #5 clk = ~clk;

  misr_signature_checker #(.WINDOW(16), .SEED(8'h00)) dut (.clk(clk), .rst_n(rst_n), .start(st[0]),
    .p1(p1), .p2(p2), .p3(p3), .gold_sig(gold), .busy(bz[0]), .done(dn[0]), .pass(ps[0]), .signature(sg[0])
`ifdef MISR_SCAN_OUT_EN
    , .scan_en(scan_en), .scan_out(so[0])
`endif
  );
  misr_signature_checker #(.WINDOW(1), .SEED(8'h80)) dut_f (.clk(clk), .rst_n(rst_n), .start(st[1]),
    .p1(p1), .p2(p2), .p3(p3), .gold_sig(gold), .busy(bz[1]), .done(dn[1]), .pass(ps[1]), .signature(sg[1])
`ifdef MISR_SCAN_OUT_EN
    , .scan_en(scan_en), .scan_out(so[1])
`endif
  );
  misr_signature_checker #(.WINDOW(2), .SEED(8'h00)) dut_s (.clk(clk), .rst_n(rst_n), .start(st[2]),
    .p1(p1), .p2(p2), .p3(p3), .gold_sig(gold), .busy(bz[2]), .done(dn[2]), .pass(ps[2]), .signature(sg[2])
`ifdef MISR_SCAN_OUT_EN
    , .scan_en(scan_en), .scan_out(so[2])
`endif
  );
  misr_signature_checker #(.WINDOW(1), .SEED(8'h00)) dut_o (.clk(clk), .rst_n(rst_n), .start(st[3]),
    .p1(p1), .p2(p2), .p3(p3), .gold_sig(gold), .busy(bz[3]), .done(dn[3]), .pass(ps[3]), .signature(sg[3])
`ifdef MISR_SCAN_OUT_EN
    , .scan_en(scan_en), .scan_out(so[3])
`endif
  );

  // Signature as polynomial arithmetic: multiply by x, reduce modulo x^8 + 0x1D, add the sample.
  function automatic logic [7:0] ref_sig(input logic [7:0] seed, input q3_t smp);
    int v = int'(seed);
    foreach (smp[i]) begin
      v = v * 2;
      if (v >= 256) v = v ^ (256 + 'h1D);
      v = v ^ int'(smp[i]);
    end
    return 8'(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int k, input q3_t smp, input logic [7:0] g, input bit hold,
                     output int bc, output logic d0, output logic b0);
    st[k] = 1'b1;
    step();
    d0 = dn[k];
    b0 = bz[k];
    st[k] = hold;
    bc = 0;
    for (int i = 0; i < smp.size(); i++) begin
      bc += int'(bz[k]);
      {p3, p2, p1} = smp[i];
      step();
    end
    bc += int'(bz[k]);
    st[k] = 1'b0;
    gold = g;
    step();
  endtask

  task automatic test_reset();
    step();
    step();
    total++; if (bz[0] !== 1'b0) $display("FAIL reset_busy: got %b want 0", bz[0]); else passed++;
    total++; if (dn[0] !== 1'b0) $display("FAIL reset_done: got %b want 0", dn[0]); else passed++;
    total++; if (ps[0] !== 1'b0) $display("FAIL reset_pass: got %b want 0", ps[0]); else passed++;
    total++; if (sg[0] !== 8'h00) $display("FAIL reset_sig: got %h want 00", sg[0]); else passed++;
    rst_n = 1'b1;
    step();
    step();
    total++; if ({bz[0], dn[0]} !== 2'b00) $display("FAIL idle_after_reset: got %b want 00", {bz[0], dn[0]}); else passed++;
  endtask

  task automatic test_all_zero();
    q3_t q;
    int bc;
    logic d0, b0;
    for (int i = 0; i < 16; i++) q.push_back(3'b000);
    run(0, q, 8'h00, 1'b0, bc, d0, b0);
    total++; if (bc !== 17) $display("FAIL zero_busy_cycles: got %0d want 17", bc); else passed++;
    total++; if ({bz[0], dn[0], ps[0]} !== 3'b011) $display("FAIL zero_flags: got %b want 011", {bz[0], dn[0], ps[0]}); else passed++;
    total++; if (sg[0] !== 8'h00) $display("FAIL zero_sig: got %h want 00", sg[0]); else passed++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      q3_t q;
      int bc;
      logic d0, b0;
      logic [7:0] e, g;
      for (int i = 0; i < 16; i++) q.push_back(3'($urandom));
      e = ref_sig(8'h00, q);
      g = ($urandom_range(0, 1) == 1) ? e : e ^ 8'($urandom_range(1, 255));
      run(0, q, g, 1'b0, bc, d0, b0);
      total++; if (sg[0] !== e) $display("FAIL rand_sig[%0d]: got %h want %h", r, sg[0], e); else passed++;
      total++; if (ps[0] !== (g == e)) $display("FAIL rand_pass[%0d]: got %b want %b", r, ps[0], g == e); else passed++;
      total++; if (bc !== 17) $display("FAIL rand_busy[%0d]: got %0d want 17", r, bc); else passed++;
      gold = ~gold;
      {p3, p2, p1} = 3'b111;
      for (int i = 0; i < 3; i++) step();
      total++; if ({dn[0], sg[0], ps[0]} !== {1'b1, e, g == e})
        $display("FAIL rand_hold[%0d]: got %b/%h/%b want 1/%h/%b", r, dn[0], sg[0], ps[0], e, g == e); else passed++;
    end
  endtask

  task automatic test_feedback();
    q3_t q = '{3'b000};
    int bc;
    logic d0, b0;
    run(1, q, 8'h1D, 1'b0, bc, d0, b0);
    total++; if (sg[1] !== 8'h1D) $display("FAIL feedback_sig: got %h want 1d", sg[1]); else passed++;
    total++; if ({dn[1], ps[1]} !== 2'b11) $display("FAIL feedback_pass: got %b want 11", {dn[1], ps[1]}); else passed++;
    total++; if (bc !== 2) $display("FAIL feedback_busy: got %0d want 2", bc); else passed++;
  endtask

  task automatic test_shift_sample();
    q3_t q = '{3'b001, 3'b000};
    int bc;
    logic d0, b0;
    run(2, q, 8'h03, 1'b0, bc, d0, b0);
    total++; if (sg[2] !== 8'h02) $display("FAIL shift_sig: got %h want 02", sg[2]); else passed++;
    total++; if ({dn[2], ps[2]} !== 2'b10) $display("FAIL shift_pass: got %b want 10", {dn[2], ps[2]}); else passed++;
  endtask

  task automatic test_mid_reset();
    q3_t q = '{3'b101};
    int bc;
    logic d0, b0;
    st[0] = 1'b1;
    step();
    st[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      {p3, p2, p1} = 3'b111;
      step();
    end
    rst_n = 1'b0;
    #1;
    total++; if ({bz[0], dn[0], ps[0], sg[0]} !== 11'h0)
      $display("FAIL midreset_async: got %b%b%b/%h want 000/00", bz[0], dn[0], ps[0], sg[0]); else passed++;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    total++; if ({bz[0], dn[0], sg[0]} !== 10'h0) $display("FAIL midreset_idle: got %b%b/%h want 00/00", bz[0], dn[0], sg[0]); else passed++;
    run(3, q, 8'h05, 1'b0, bc, d0, b0);
    total++; if (sg[3] !== 8'h05) $display("FAIL midreset_restart_sig: got %h want 05", sg[3]); else passed++;
    total++; if (ps[3] !== 1'b1) $display("FAIL midreset_restart_pass: got %b want 1", ps[3]); else passed++;
  endtask

  task automatic test_start_hold();
    q3_t q;
    int bc;
    logic d0, b0;
    logic [7:0] e;
    for (int i = 0; i < 16; i++) q.push_back(3'($urandom));
    e = ref_sig(8'h00, q);
    run(0, q, e, 1'b1, bc, d0, b0);
    total++; if (bc !== 17) $display("FAIL hold_busy: got %0d want 17", bc); else passed++;
    total++; if ({dn[0], ps[0], sg[0]} !== {2'b11, e}) $display("FAIL hold_result: got %b%b/%h want 11/%h", dn[0], ps[0], sg[0], e); else passed++;
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 2; r++) begin
      q3_t q;
      int bc;
      logic d0, b0;
      logic [7:0] e;
      for (int i = 0; i < 16; i++) q.push_back(3'($urandom));
      e = ref_sig(8'h00, q);
      run(0, q, e, 1'b0, bc, d0, b0);
      total++; if ({d0, b0} !== 2'b01) $display("FAIL b2b_restart[%0d]: got done/busy %b%b want 01", r, d0, b0); else passed++;
      total++; if ({sg[0], ps[0]} !== {e, 1'b1}) $display("FAIL b2b_result[%0d]: got %h/%b want %h/1", r, sg[0], ps[0], e); else passed++;
    end
  endtask

`ifdef MISR_SCAN_OUT_EN
  task automatic test_scan();
    q3_t q;
    int bc;
    logic d0, b0;
    logic [7:0] pat = 8'hA5;
    for (int i = 0; i < 8; i++) q.push_back(3'b000);
    for (int i = 7; i >= 0; i--) q.push_back({2'b00, pat[i]});
    run(0, q, 8'hA5, 1'b0, bc, d0, b0);
    total++; if (sg[0] !== 8'hA5) $display("FAIL scan_load: got %h want a5", sg[0]); else passed++;
    scan_en = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      total++; if (so[0] !== pat[i]) $display("FAIL scan_out[%0d]: got %b want %b", i, so[0], pat[i]); else passed++;
      step();
    end
    scan_en = 1'b0;
    total++; if ({sg[0], ps[0]} !== {8'h00, 1'b1}) $display("FAIL scan_final: got %h/%b want 00/1", sg[0], ps[0]); else passed++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_all_zero();
    test_random();
    test_feedback();
    test_shift_sample();
    test_mid_reset();
    test_start_hold();
    test_back_to_back();
`ifdef MISR_SCAN_OUT_EN
    test_scan();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
